// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared constants for the sweep sequencer and its up/down counter:
// FSM state encodings and the direction convention (1 = up, 0 = down).
package updown_sweep_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter_en.sv
// Up/down counter with synchronous load and count enable.
// Load has priority over enable; the count direction follows dir.
module updown_counter_en
    import updown_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en) begin
            if (dir == DIR_UP) begin
                r_count <= r_count + WIDTH'(1);
            end else begin
                r_count <= r_count - WIDTH'(1);
            end
        end
    end

    assign count = r_count;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer: runs the counter lo->hi->lo for a programmed number of
// sweeps, with hold/abort control and busy/done/err status.
module updown_sweep_ctrl
    import updown_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH   = 9,
    parameter int SWEEP_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               hold,
    input  logic [WIDTH-1:0]   lo_bound,
    input  logic [WIDTH-1:0]   hi_bound,
    input  logic [SWEEP_W-1:0] num_sweeps,
    output logic [WIDTH-1:0]   count,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic               err
);

    logic [1:0]         r_state;
    logic               r_dir;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [SWEEP_W-1:0] r_sweeps;
    logic               r_err;

    logic [1:0]         w_state_next;
    logic               w_dir_next;
    logic [SWEEP_W-1:0] w_sweeps_next;
    logic               w_cnt_en;
    logic               w_step_dir;
    logic               w_bad_cmd;
    logic               w_accept;
    logic               w_at_hi;
    logic               w_at_lo;
    logic [WIDTH-1:0]   w_count;

    assign w_bad_cmd = (lo_bound >= hi_bound) || (num_sweeps == '0);
    assign w_accept  = (r_state == ST_IDLE) && start && !w_bad_cmd;
    assign w_at_hi   = (w_count == r_hi);
    assign w_at_lo   = (w_count == r_lo);

    // The counter steps on the same edge that flips dir, so it is fed the
    // direction of the step being taken rather than the registered dir.
    always_comb begin
        w_state_next  = r_state;
        w_dir_next    = r_dir;
        w_sweeps_next = r_sweeps;
        w_cnt_en      = 1'b0;
        w_step_dir    = r_dir;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next  = ST_UP;
                    w_dir_next    = DIR_UP;
                    w_sweeps_next = num_sweeps;
                end
            end
            ST_UP: begin
                if (abort) begin
                    w_state_next  = ST_IDLE;
                    w_sweeps_next = '0;
                end else if (!hold) begin
                    w_cnt_en = 1'b1;
                    if (w_at_hi) begin
                        w_step_dir   = DIR_DOWN;
                        w_dir_next   = DIR_DOWN;
                        w_state_next = ST_DOWN;
                    end else begin
                        w_step_dir = DIR_UP;
                    end
                end
            end
            ST_DOWN: begin
                if (abort) begin
                    w_state_next  = ST_IDLE;
                    w_sweeps_next = '0;
                end else if (!hold) begin
                    if (!w_at_lo) begin
                        w_cnt_en   = 1'b1;
                        w_step_dir = DIR_DOWN;
                    end else if (r_sweeps > SWEEP_W'(1)) begin
                        w_cnt_en      = 1'b1;
                        w_step_dir    = DIR_UP;
                        w_dir_next    = DIR_UP;
                        w_sweeps_next = r_sweeps - SWEEP_W'(1);
                        w_state_next  = ST_UP;
                    end else begin
                        w_state_next  = ST_DONE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_dir    <= DIR_UP;
            r_lo     <= '0;
            r_hi     <= '0;
            r_sweeps <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_dir    <= w_dir_next;
            r_sweeps <= w_sweeps_next;
            r_err    <= (r_state == ST_IDLE) && start && w_bad_cmd;
            if (w_accept) begin
                r_lo <= lo_bound;
                r_hi <= hi_bound;
            end
        end
    end

    updown_counter_en #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (w_accept),
        .load_val (lo_bound),
        .en       (w_cnt_en),
        .dir      (w_step_dir),
        .count    (w_count)
    );

    assign count = w_count;
    assign dir   = r_dir;
    assign busy  = (r_state == ST_UP) || (r_state == ST_DOWN);
    assign done  = (r_state == ST_DONE);
    assign err   = r_err;

endmodule
